// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_seq_pkg
//  Description : Shared types and constants for the SAR ADC sequencer:
//                state encoding, comparator phase length, default result
//                width and the bit-count clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_seq_pkg;

    localparam int ADC_SEQ_MAX_BITS    = 16;
    localparam int ADC_SEQ_COMP_CYCLES = 2;
    localparam int ADC_SEQ_STATE_W     = 3;

    typedef enum logic [ADC_SEQ_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SAMP   = 3'd2,
        ST_COMP1  = 3'd3,
        ST_COMP2  = 3'd4,
        ST_UPDATE = 3'd5,
        ST_DONE   = 3'd6
    } adc_seq_state_t;

    // Effective bit count: 0 behaves as 1, anything above max_bits saturates.
    function automatic logic [4:0] eff_nbits(input logic [4:0] n, input int max_bits);
        if (n == 5'd0) begin
            return 5'd1;
        end
        if (int'(n) > max_bits) begin
            return 5'(max_bits);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sequencer
//  Description : Timing-strobe generator and result collector for the SAR ADC
//                macro. One conversion per start (or back-to-back in
//                continuous mode), MSB-first shift of comp_out, result
//                handed to readout over valid/ready with a sticky overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int MAX_BITS = ADC_SEQ_MAX_BITS,  // 2..31 (bit counter is 5 bits)
    parameter int SAMP_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [SAMP_W-1:0]   cfg_samp_cycles,
    input  logic [4:0]          cfg_nbits,
    input  logic                cfg_continuous,
    input  logic                comp_out,
    output logic                seq_init,
    output logic                seq_samp,
    output logic                seq_comp,
    output logic                seq_update,
    output logic                busy,
    output logic [MAX_BITS-1:0] result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                overrun
);

    localparam logic [SAMP_W-1:0] SAMP_ONE = SAMP_W'(1);

    adc_seq_state_t      state_q, state_d;
    logic [SAMP_W-1:0]   samp_len_q;
    logic [SAMP_W-1:0]   samp_cnt_q;
    logic [4:0]          nbits_q;
    logic [4:0]          bit_cnt_q;
    logic                cont_q;
    logic [MAX_BITS-1:0] shreg_q;
    logic [MAX_BITS-1:0] result_q;
    logic                result_valid_q;
    logic                overrun_q;
    logic                seq_init_q, seq_samp_q, seq_comp_q, seq_update_q;
    logic                busy_q;
    logic                handshake;
    logic                commit;

    assign handshake = result_valid_q && result_ready;
    // An abort landing on the DONE cycle suppresses the result.
    assign commit    = (state_q == ST_DONE) && !abort;

    // Next-state decode; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_INIT;
            ST_INIT:   state_d = ST_SAMP;
            ST_SAMP:   if (samp_cnt_q == SAMP_ONE) state_d = ST_COMP1;
            ST_COMP1:  state_d = ST_COMP2;
            ST_COMP2:  state_d = ST_UPDATE;
            ST_UPDATE: state_d = (bit_cnt_q == 5'd1) ? ST_DONE : ST_COMP1;
            ST_DONE:   state_d = cont_q ? ST_INIT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // State, counters, shift register, registered strobes and output buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            samp_len_q     <= '0;
            samp_cnt_q     <= '0;
            nbits_q        <= '0;
            bit_cnt_q      <= '0;
            cont_q         <= 1'b0;
            shreg_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            seq_init_q     <= 1'b0;
            seq_samp_q     <= 1'b0;
            seq_comp_q     <= 1'b0;
            seq_update_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q <= state_d;

            // Strobes are decoded from the next state so they line up with it.
            seq_init_q   <= (state_d == ST_INIT);
            seq_samp_q   <= (state_d == ST_SAMP);
            seq_comp_q   <= (state_d == ST_COMP1) || (state_d == ST_COMP2);
            seq_update_q <= (state_d == ST_UPDATE);
            busy_q       <= (state_d != ST_IDLE);

            // Configuration is frozen for the whole run (including restarts).
            if (state_q == ST_IDLE && state_d == ST_INIT) begin
                samp_len_q <= (cfg_samp_cycles == '0) ? SAMP_ONE : cfg_samp_cycles;
                nbits_q    <= eff_nbits(cfg_nbits, MAX_BITS);
                cont_q     <= cfg_continuous;
            end

            case (state_q)
                ST_INIT: begin
                    shreg_q    <= '0;
                    bit_cnt_q  <= nbits_q;
                    samp_cnt_q <= samp_len_q;
                end
                ST_SAMP:   samp_cnt_q <= samp_cnt_q - SAMP_ONE;
                ST_COMP2:  shreg_q    <= {shreg_q[MAX_BITS-2:0], comp_out};
                ST_UPDATE: bit_cnt_q  <= bit_cnt_q - 5'd1;
                default: ;
            endcase

            // Output buffer: load if empty or being drained, else flag overrun.
            if (handshake) begin
                overrun_q <= 1'b0;
            end
            if (commit) begin
                if (!result_valid_q || result_ready) begin
                    result_q       <= shreg_q;
                    result_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (handshake) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    assign seq_init     = seq_init_q;
    assign seq_samp     = seq_samp_q;
    assign seq_comp     = seq_comp_q;
    assign seq_update   = seq_update_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_sequencer
//  Description : Self-checking bench for adc_sequencer. A schedule-based
//                reference model predicts strobes, busy and buffer flags per
//                cycle and queues expected result codes; a monitor pops the
//                queue whenever the DUT presents a new result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sequencer;

    localparam int MAXB = 16;

    logic            clk = 1'b0;
    logic            rst, start, abort, cfg_continuous, comp_out, result_ready;
    logic [7:0]      cfg_samp_cycles;
    logic [4:0]      cfg_nbits;
    logic            seq_init, seq_samp, seq_comp, seq_update, busy;
    logic [MAXB-1:0] result;
    logic            result_valid, overrun;

    always #5 clk = ~clk;

    adc_sequencer #(.MAX_BITS(MAXB), .SAMP_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cfg_samp_cycles (cfg_samp_cycles),
        .cfg_nbits       (cfg_nbits),
        .cfg_continuous  (cfg_continuous),
        .comp_out        (comp_out),
        .seq_init        (seq_init),
        .seq_samp        (seq_samp),
        .seq_comp        (seq_comp),
        .seq_update      (seq_update),
        .busy            (busy),
        .result          (result),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .overrun         (overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    bit              comp_hist [0:65535];
    logic [MAXB-1:0] exp_q [$];

    // Reference model state: one conversion window [m_e0, m_e0+len-1].
    bit              m_active = 1'b0;
    int              m_e0 = 0, m_s = 1, m_n = 1;
    bit              m_cont = 1'b0;
    bit              m_rv = 1'b0, m_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    endtask

    function automatic int conv_len(input int s, input int n);
        return s + 3 * n + 2;
    endfunction

    // Strobes {init,samp,comp,update} k cycles after INIT is entered.
    function automatic logic [3:0] sched(input int k, input int s, input int n);
        if (k == 0) return 4'b1000;
        if (k <= s) return 4'b0100;
        if (k <= s + 3 * n) return (((k - s - 1) % 3) < 2) ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    // One clock: drive inputs, advance the model to the coming edge, check after it.
    task automatic step(input bit st, input bit ab, input bit rdy, input bit rs, input int cmp);
        int              t;
        bit              hs, xfer;
        logic [MAXB-1:0] code;
        logic [3:0]      exp_strb;
        t            = cyc + 1;
        rst          = rs;
        start        = st;
        abort        = ab;
        result_ready = rdy;
        comp_out     = (cmp < 0) ? 1'($urandom) : 1'(cmp);
        comp_hist[t] = comp_out;
        if (rs) begin
            m_active = 1'b0; m_rv = 1'b0; m_ovr = 1'b0;
            exp_q.delete();
        end else begin
            hs   = m_rv && rdy;
            xfer = 1'b0;
            code = '0;
            if (ab) begin
                m_active = 1'b0;
            end else if (m_active && t == m_e0 + conv_len(m_s, m_n)) begin
                xfer = 1'b1;
                for (int i = 0; i < m_n; i++)
                    code = {code[MAXB-2:0], comp_hist[m_e0 + m_s + 3 + 3 * i]};
                if (m_cont) m_e0 = t;
                else        m_active = 1'b0;
            end else if (!m_active && st) begin
                m_active = 1'b1;
                m_e0     = t;
                m_s      = (cfg_samp_cycles == 8'd0) ? 1 : int'(cfg_samp_cycles);
                m_n      = (cfg_nbits == 5'd0) ? 1 : ((int'(cfg_nbits) > MAXB) ? MAXB : int'(cfg_nbits));
                m_cont   = cfg_continuous;
            end
            if (xfer && (!m_rv || rdy)) begin
                m_rv = 1'b1;
                exp_q.push_back(code);
            end else if (xfer) begin
                m_ovr = 1'b1;
            end
            if (hs) begin
                m_ovr = 1'b0;
                if (!xfer) m_rv = 1'b0;
            end
        end
        @(posedge clk);
        cyc = t;
        @(negedge clk);
        exp_strb = m_active ? sched(t - m_e0, m_s, m_n) : 4'b0000;
        check("strobes", 32'({seq_init, seq_samp, seq_comp, seq_update}), 32'(exp_strb));
        check("busy", 32'(busy), 32'(m_active));
        check("result_valid", 32'(result_valid), 32'(m_rv));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // Monitor: a new result is presented when valid rises or is refilled during a handshake.
    logic mon_rv, mon_rd;
    always @(posedge clk) begin
        mon_rv = result_valid;
        mon_rd = result_ready;
        #1;
        if (result_valid === 1'b1 && (mon_rv === 1'b0 || (mon_rv === 1'b1 && mon_rd === 1'b1))) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL result_unexpected: got %0h expected none queued (edge %0d)", result, cyc);
            end else begin
                check("result", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, c_init, c_samp, c_comp, c_upd, cmp;
        logic [3:0]      pat;
        logic [MAXB-1:0] held;
        cfg_samp_cycles = 8'd1; cfg_nbits = 5'd1; cfg_continuous = 1'b0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; comp_out = 1'b0; result_ready = 1'b0;

        // Reset state
        step(1, 0, 0, 1, -1);
        step(0, 0, 0, 1, -1);
        check("reset_result", 32'(result), 32'd0);

        // S=3, N=4, comp 1,0,1,1 -> 0x000B, valid at edge S+3N+2 = 17
        cfg_samp_cycles = 8'd3; cfg_nbits = 5'd4; cfg_continuous = 1'b0;
        pat = 4'b1011;
        step(1, 0, 0, 0, -1);
        e0 = cyc;
        c_init = int'(seq_init); c_samp = int'(seq_samp); c_comp = int'(seq_comp); c_upd = int'(seq_update);
        for (int k = 1; k <= 17; k++) begin
            cmp = -1;
            for (int i = 0; i < 4; i++) if (k == 6 + 3 * i) cmp = int'(pat[3 - i]);
            if (k == 2) begin cfg_nbits = 5'd9; cfg_samp_cycles = 8'd7; end
            step(0, 0, 0, 0, cmp);
            c_init += int'(seq_init); c_samp += int'(seq_samp);
            c_comp += int'(seq_comp); c_upd  += int'(seq_update);
            if (k == 16) check("s3n4_valid_before", 32'(result_valid), 32'd0);
            if (k == 17) begin
                check("s3n4_valid_at", 32'(result_valid), 32'd1);
                check("s3n4_code", 32'(result), 32'h000B);
            end
        end
        check("s3n4_n_init", 32'(c_init), 32'd1);
        check("s3n4_n_samp", 32'(c_samp), 32'd3);
        check("s3n4_n_comp", 32'(c_comp), 32'd8);
        check("s3n4_n_update", 32'(c_upd), 32'd4);
        step(0, 0, 1, 0, -1);
        check("s3n4_drained", 32'(result_valid), 32'd0);

        // S=0, N=0 treated as 1,1: valid at edge 6
        cfg_samp_cycles = 8'd0; cfg_nbits = 5'd0;
        step(1, 0, 0, 0, -1);
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, 0, 0, (k == 4) ? 1 : -1);
            if (k == 5) check("s0n0_valid_before", 32'(result_valid), 32'd0);
            if (k == 6) begin
                check("s0n0_valid_at", 32'(result_valid), 32'd1);
                check("s0n0_code", 32'(result), 32'h0001);
            end
        end
        step(0, 0, 1, 0, -1);

        // Continuous S=2, N=16, ready low: second result dropped -> overrun
        cfg_samp_cycles = 8'd2; cfg_nbits = 5'd16; cfg_continuous = 1'b1;
        step(1, 0, 0, 0, -1);
        for (int k = 1; k <= 106; k++) step(0, 0, 0, 0, -1);
        check("cont_valid_held", 32'(result_valid), 32'd1);
        check("cont_overrun", 32'(overrun), 32'd1);
        step(0, 1, 0, 0, -1);
        step(0, 0, 1, 0, -1);
        check("cont_clear_valid", 32'(result_valid), 32'd0);
        check("cont_clear_overrun", 32'(overrun), 32'd0);

        // DONE coincident with ready while valid: new code replaces old, no overrun
        cfg_samp_cycles = 8'd1; cfg_nbits = 5'd1; cfg_continuous = 1'b0;
        step(1, 0, 0, 0, -1);
        for (int k = 1; k <= 7; k++) step(0, 0, 0, 0, (k == 4) ? 1 : -1);
        check("first_code", 32'(result), 32'h0001);
        step(1, 0, 0, 0, -1);
        for (int k = 1; k <= 7; k++) begin
            step(0, 0, (k == 6), 0, (k == 4) ? 0 : -1);
            if (k == 6) begin
                check("swap_valid", 32'(result_valid), 32'd1);
                check("swap_overrun", 32'(overrun), 32'd0);
                check("swap_code", 32'(result), 32'h0000);
            end
        end

        // Abort in COMP2 of bit 5 (S=2, N=8) with start in the same cycle
        held = result;
        cfg_samp_cycles = 8'd2; cfg_nbits = 5'd8;
        step(1, 0, 0, 0, -1);
        for (int k = 1; k <= 16; k++) step(0, 0, 0, 0, -1);
        step(1, 1, 0, 0, -1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, -1);
            check("abort_idle", 32'(busy), 32'd0);
        end
        check("abort_result_held", 32'(result), 32'(held));

        // Reset mid-SAMP, then start honoured right away
        cfg_samp_cycles = 8'd5; cfg_nbits = 5'd3;
        step(1, 0, 0, 0, -1);
        step(0, 0, 0, 0, -1);
        step(0, 0, 0, 0, -1);
        step(0, 0, 0, 1, -1);
        check("rst_mid_outputs", 32'({seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, overrun}), 32'd0);
        check("rst_mid_result", 32'(result), 32'd0);
        step(1, 0, 0, 0, -1);
        check("rst_then_start", 32'(seq_init), 32'd1);
        for (int k = 1; k <= 17; k++) step(0, 0, 0, 0, -1);
        step(0, 0, 1, 0, -1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cfg_samp_cycles = 8'($urandom_range(0, 6));
            cfg_nbits       = 5'($urandom_range(0, 18));
            cfg_continuous  = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 999) == 0), -1);
        end
        step(0, 1, 0, 0, -1);
        step(0, 0, 1, 0, -1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
